vga_cursor_ctl: RTL

//  Wishbone register block upstream of the text VGA adapter. It owns cursor

---
 rtl/vga_cursor_ctl_if.sv | 22 ++
 rtl/vga_cursor_ctl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/vga_cursor_ctl_if.sv
// Wishbone slave bus carrying the cursor controller's register accesses.
// The signal names match the adapter-side Wishbone naming used by the firmware.
interface vga_cursor_ctl_if;
  logic [15:0] wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [1:0]  wb_sel_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/vga_cursor_ctl.sv
// Cursor position/style register block for the text VGA adapter, with
// terminal-style advance/newline/home commands and vsync-driven blink phases.
module vga_cursor_ctl #(
  parameter int COLS          = 80,
  parameter int ROWS          = 25,
  parameter int FLASH_FRAMES  = 30,
  parameter int CURSOR_FRAMES = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  vga_cursor_ctl_if.slave       wb,
  input  logic                  vsync_i,
  output logic [12:0]           cursor,
  output logic                  cursor_on,
  output logic                  cursor_type,
  output logic                  flash,
  output logic                  scroll_req
);

  localparam logic [6:0]  X_MAX  = 7'(COLS - 1);
  localparam logic [4:0]  Y_MAX  = 5'(ROWS - 1);
  localparam int          FW     = $clog2(FLASH_FRAMES + 1);
  localparam int          CW     = $clog2(CURSOR_FRAMES + 1);
  localparam logic [FW-1:0] F_LAST = FW'(FLASH_FRAMES - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CURSOR_FRAMES - 1);
  localparam logic [12:0] COLS13 = 13'(COLS);

  logic [6:0]    r_x, w_x_nxt;
  logic [4:0]    r_y, w_y_nxt;
  logic [2:0]    r_ctrl, w_ctrl_nxt;
  logic          r_sp, w_sp_nxt;
  logic          w_scroll;
  logic          w_step;
  logic          r_ack;
  logic [15:0]   r_dat;
  logic [15:0]   w_rd_mux;
  logic          w_reply;
  logic          w_wr;
  logic [1:0]    w_reg;
  logic          r_vs_s1, r_vs_s2, r_vs_d;
  logic          w_tick;
  logic [FW-1:0] r_fcnt;
  logic [CW-1:0] r_ccnt;
  logic          r_flash, r_cphase;
  logic [12:0]   r_cursor;
  logic          r_cursor_on, r_cursor_type, r_flash_o, r_scroll;
  logic          w_unused;

  // Handshake: a transfer is taken when cyc&stb are high and ack is low; ack
  // then rises for exactly one cycle, so a held strobe sees ack every other cycle.
  assign w_reply = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
  assign w_wr    = w_reply & wb.wb_we_i & wb.wb_sel_i[0];
  assign w_reg   = wb.wb_adr_i[2:1];
  assign w_tick  = r_vs_s2 & ~r_vs_d;

  always_comb begin
    w_rd_mux = 16'h0000;
    case (w_reg)
      2'd0: w_rd_mux = {9'b0, r_x};
      2'd1: w_rd_mux = {11'b0, r_y};
      2'd2: w_rd_mux = {13'b0, r_ctrl};
      default: w_rd_mux = {13'b0, r_cphase, r_flash, r_sp};
    endcase
  end

  always_comb begin
    w_x_nxt    = r_x;
    w_y_nxt    = r_y;
    w_ctrl_nxt = r_ctrl;
    w_sp_nxt   = r_sp;
    w_scroll   = 1'b0;
    w_step     = 1'b0;
    if (w_wr) begin
      case (w_reg)
        2'd0: w_x_nxt = (wb.wb_dat_i[6:0] > X_MAX) ? X_MAX : wb.wb_dat_i[6:0];
        2'd1: w_y_nxt = (wb.wb_dat_i[4:0] > Y_MAX) ? Y_MAX : wb.wb_dat_i[4:0];
        2'd2: w_ctrl_nxt = wb.wb_dat_i[2:0];
        default: begin
          if (wb.wb_dat_i[2]) begin
            w_x_nxt = 7'd0;
            w_y_nxt = 5'd0;
          end else if (wb.wb_dat_i[1]) begin
            w_x_nxt = 7'd0;
            w_step  = 1'b1;
          end else if (wb.wb_dat_i[0]) begin
            if (r_x < X_MAX) begin
              w_x_nxt = r_x + 7'd1;
            end else begin
              w_x_nxt = 7'd0;
              w_step  = 1'b1;
            end
          end
          // Clear first so a scroll raised by the same write wins.
          if (wb.wb_dat_i[7]) w_sp_nxt = 1'b0;
          if (w_step) begin
            if (r_y < Y_MAX) begin
              w_y_nxt = r_y + 5'd1;
            end else begin
              w_sp_nxt = 1'b1;
              w_scroll = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_x      <= 7'd0;
      r_y      <= 5'd0;
      r_ctrl   <= 3'b101;
      r_sp     <= 1'b0;
      r_ack    <= 1'b0;
      r_dat    <= 16'h0000;
      r_scroll <= 1'b0;
    end else begin
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_ctrl   <= w_ctrl_nxt;
      r_sp     <= w_sp_nxt;
      r_ack    <= w_reply;
      r_scroll <= w_scroll;
      if (w_reply && !wb.wb_we_i) r_dat <= w_rd_mux;
    end
  end

  // vsync is from the pixel domain; synchronise before edge detection.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_vs_s1  <= 1'b0;
      r_vs_s2  <= 1'b0;
      r_vs_d   <= 1'b0;
      r_fcnt   <= '0;
      r_ccnt   <= '0;
      r_flash  <= 1'b1;
      r_cphase <= 1'b1;
    end else begin
      r_vs_s1 <= vsync_i;
      r_vs_s2 <= r_vs_s1;
      r_vs_d  <= r_vs_s2;
      if (w_tick) begin
        if (r_fcnt == F_LAST) begin
          r_fcnt  <= '0;
          r_flash <= ~r_flash;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
        if (r_ccnt == C_LAST) begin
          r_ccnt   <= '0;
          r_cphase <= ~r_cphase;
        end else begin
          r_ccnt <= r_ccnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_cursor      <= 13'd0;
      r_cursor_on   <= 1'b0;
      r_cursor_type <= 1'b0;
      r_flash_o     <= 1'b1;
    end else begin
      r_cursor      <= 13'(r_y) * COLS13 + 13'(r_x);
      r_cursor_on   <= r_ctrl[0] & (~r_ctrl[2] | r_cphase);
      r_cursor_type <= r_ctrl[1];
      r_flash_o     <= r_flash;
    end
  end

  assign wb.wb_ack_o = r_ack;
  assign wb.wb_dat_o = r_dat;
  assign cursor      = r_cursor;
  assign cursor_on   = r_cursor_on;
  assign cursor_type = r_cursor_type;
  assign flash       = r_flash_o;
  assign scroll_req  = r_scroll;

  assign w_unused = &{1'b0, wb.wb_adr_i[15:3], wb.wb_adr_i[0],
                      wb.wb_dat_i[15:8], wb.wb_sel_i[1]};

endmodule
